// File: rtl/booth_radix4_mul.sv
// ---------------------------------------------------------------------------
// booth_radix4_mul
//   Sequential radix-4 (modified) Booth multiplier. Both operands arrive on
//   the shared ibus: the multiplicand with bgn, the multiplier one cycle
//   later. W/2 add/shift iterations follow. The 2W-bit product then leaves
//   on obus, low word first and high word second.
//
//   Optional feature macro: BOOTH_UNSIGNED_EN
//     When it is defined, the sgn port is added. sgn is captured with bgn.
//     sgn=0 selects unsigned operands, which take one extra iteration.
//     sgn=1 gives the same behaviour as the default build.
//
// Ports
//   clk   in   1  rising-edge clock
//   rst   in   1  synchronous active-high reset
//   bgn   in   1  start request, sampled only when idle
//   sgn   in   1  signed(1)/unsigned(0) select; only with BOOTH_UNSIGNED_EN
//   ibus  in   W  operand bus (multiplicand on bgn cycle, multiplier next)
//   obus  out  W  product bus: low word, then high word, otherwise 0
//   stop  out  1  high during the high-word cycle
//   busy  out  1  high while an operation is in flight
// ---------------------------------------------------------------------------
module booth_radix4_mul #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bgn,
`ifdef BOOTH_UNSIGNED_EN
  input  logic         sgn,
`endif
  input  logic [W-1:0] ibus,
  output logic [W-1:0] obus,
  output logic         stop,
  output logic         busy
);

  if (((W % 2) != 0) || (W < 4)) begin : g_bad_width
    $error("booth_radix4_mul: W must be even and >= 4");
  end

  // A carries two guard bits so that +-2M never overflows.
  localparam int AW = W + 2;
`ifdef BOOTH_UNSIGNED_EN
  // The multiplier is widened so an unsigned operand can be zero-extended.
  localparam int QW = W + 2;
`else
  localparam int QW = W;
`endif
  localparam int CW = $clog2(W / 2 + 1);
  localparam logic [CW-1:0] LAST_SGN = CW'(W / 2 - 1);
  localparam logic [CW-1:0] LAST_UNS = CW'(W / 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_Y = 3'd1,
    S_CALC   = 3'd2,
    S_OUT_LO = 3'd3,
    S_OUT_HI = 3'd4
  } state_t;

  // Radix-4 Booth recoding of {Q[1],Q[0],q_m1} into a partial-product term.
  function automatic logic [AW-1:0] booth_term(input logic [2:0] bits,
                                               input logic [AW-1:0] m);
    logic [AW-1:0] m2;
    m2 = {m[AW-2:0], 1'b0};
    case (bits)
      3'b001, 3'b010: booth_term = m;
      3'b011:         booth_term = m2;
      3'b100:         booth_term = -m2;
      3'b101, 3'b110: booth_term = -m;
      default:        booth_term = {AW{1'b0}};  // 000 / 111
    endcase
  endfunction

  state_t         state_r;
  logic [AW-1:0]  a_r;
  logic [QW-1:0]  q_r;
  logic [AW-1:0]  m_r;
  logic [CW-1:0]  cnt_r;
  logic           qm1_r;
  logic [W-1:0]   obus_r;
  logic           stop_r;
  logic           busy_r;
`ifdef BOOTH_UNSIGNED_EN
  logic           sgn_r;
`endif

  logic [AW-1:0]  term_s;
  logic [AW:0]    sum_s;
  logic [AW-1:0]  a_nxt_s;
  logic [QW-1:0]  q_nxt_s;
  logic [W-1:0]   lo_s;
  logic [W-1:0]   hi_s;
  logic [CW-1:0]  last_s;

  // One Booth step plus product-word selection for the active mode.
  always_comb begin
    term_s  = booth_term({q_r[1:0], qm1_r}, m_r);
    // The sum is one bit wider than A, so the arithmetic shift always sees the true sign.
    sum_s   = {a_r[AW-1], a_r} + {term_s[AW-1], term_s};
    a_nxt_s = {sum_s[AW], sum_s[AW:2]};
    q_nxt_s = {sum_s[1:0], q_r[QW-1:2]};
`ifdef BOOTH_UNSIGNED_EN
    if (sgn_r) begin
      // W shifts leave the low product word in the top W bits of the wide Q.
      lo_s   = q_r[W+1:2];
      hi_s   = a_r[W-1:0];
      last_s = LAST_SGN;
    end else begin
      lo_s   = q_r[W-1:0];
      hi_s   = {a_r[W-3:0], q_r[W+1:W]};
      last_s = LAST_UNS;
    end
`else
    lo_s   = q_r;
    hi_s   = a_r[W-1:0];
    last_s = LAST_SGN;
`endif
  end

  // Control FSM, datapath registers, and outputs registered from the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      a_r     <= {AW{1'b0}};
      q_r     <= {QW{1'b0}};
      m_r     <= {AW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      qm1_r   <= 1'b0;
      obus_r  <= {W{1'b0}};
      stop_r  <= 1'b0;
      busy_r  <= 1'b0;
`ifdef BOOTH_UNSIGNED_EN
      sgn_r   <= 1'b1;
`endif
    end else begin
      obus_r <= (state_r == S_OUT_LO) ? lo_s :
                (state_r == S_OUT_HI) ? hi_s : {W{1'b0}};
      stop_r <= (state_r == S_OUT_HI);
      busy_r <= (state_r != S_IDLE);
      case (state_r)
        S_IDLE: begin
          if (bgn) begin
`ifdef BOOTH_UNSIGNED_EN
            sgn_r <= sgn;
            m_r   <= sgn ? {{2{ibus[W-1]}}, ibus} : {2'b00, ibus};
`else
            m_r   <= {{2{ibus[W-1]}}, ibus};
`endif
            state_r <= S_LOAD_Y;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_LOAD_Y: begin
`ifdef BOOTH_UNSIGNED_EN
          q_r <= sgn_r ? {{2{ibus[W-1]}}, ibus} : {2'b00, ibus};
`else
          q_r <= ibus;
`endif
          a_r     <= {AW{1'b0}};
          qm1_r   <= 1'b0;
          cnt_r   <= {CW{1'b0}};
          state_r <= S_CALC;
        end
        S_CALC: begin
          a_r   <= a_nxt_s;
          q_r   <= q_nxt_s;
          qm1_r <= q_r[1];
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == last_s) begin
            state_r <= S_OUT_LO;
          end else begin
            state_r <= S_CALC;
          end
        end
        S_OUT_LO: state_r <= S_OUT_HI;
        S_OUT_HI: state_r <= S_IDLE;
        default:  state_r <= S_IDLE;
      endcase
    end
  end

  assign obus = obus_r;
  assign stop = stop_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_booth_radix4_mul.sv
module tb_booth_radix4_mul;

  logic        clk;
  logic        rst;
  logic        bgn;
  logic        sgn;
  logic [7:0]  ibus;
  logic [7:0]  obus;
  logic        stop;
  logic        busy;

  logic        bgn16;
  logic [15:0] ibus16;
  logic [15:0] obus16;
  logic        stop16;
  logic        busy16;

  int n_assert;
  int n_fail;
  int stops;

  booth_radix4_mul #(.W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bgn  (bgn),
`ifdef BOOTH_UNSIGNED_EN
    .sgn  (sgn),
`endif
    .ibus (ibus),
    .obus (obus),
    .stop (stop),
    .busy (busy)
  );

  booth_radix4_mul #(.W(16)) dut16 (
    .clk  (clk),
    .rst  (rst),
    .bgn  (bgn16),
`ifdef BOOTH_UNSIGNED_EN
    .sgn  (1'b1),
`endif
    .ibus (ibus16),
    .obus (obus16),
    .stop (stop16),
    .busy (busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step k drives the inputs sampled at edge k (edge 0 = bgn) and then checks the outputs after that edge.
  // bm[k] holds bgn high at edge k (k >= 1). extra = 1 for unsigned mode.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] lo, input logic [7:0] hi,
                     input logic [15:0] bm, input int extra,
                     input logic s, input string tag);
    for (int k = 0; k <= 7 + extra; k++) begin
      bgn  = (k == 0) ? 1'b1 : bm[k];
      ibus = (k == 0) ? a : ((k == 1) ? b : 8'($urandom));
      sgn  = (k == 0) ? s : 1'($urandom);
      @(negedge clk);
      if (k == 0) begin
        chk({tag, "/busy_e0"}, 32'(busy), 32'h0);
      end else if (k == 5 + extra) begin
        chk({tag, "/obus_pre"}, 32'(obus), 32'h0);
      end else if (k == 6 + extra) begin
        chk({tag, "/lo"}, 32'(obus), 32'(lo));
        chk({tag, "/stop_lo"}, 32'(stop), 32'h0);
        chk({tag, "/busy_lo"}, 32'(busy), 32'h1);
      end else if (k == 7 + extra) begin
        chk({tag, "/hi"}, 32'(obus), 32'(hi));
        chk({tag, "/stop_hi"}, 32'(stop), 32'h1);
        chk({tag, "/busy_hi"}, 32'(busy), 32'h1);
      end
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      bgn  = 1'b0;
      ibus = 8'($urandom);
      @(negedge clk);
      chk({tag, "/idle_obus"}, 32'(obus), 32'h0);
      chk({tag, "/idle_stop"}, 32'(stop), 32'h0);
      chk({tag, "/idle_busy"}, 32'(busy), 32'h0);
    end
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] lo, input logic [15:0] hi);
    for (int k = 0; k <= 12; k++) begin
      bgn16  = (k == 0);
      ibus16 = (k == 0) ? a : ((k == 1) ? b : 16'($urandom));
      @(negedge clk);
      if (k == 9) begin
        chk("w16/obus_pre", 32'(obus16), 32'h0);
        chk("w16/stop_pre", 32'(stop16), 32'h0);
      end else if (k == 10) begin
        chk("w16/lo", 32'(obus16), 32'(lo));
        chk("w16/stop_lo", 32'(stop16), 32'h0);
      end else if (k == 11) begin
        chk("w16/hi", 32'(obus16), 32'(hi));
        chk("w16/stop_hi", 32'(stop16), 32'h1);
      end else if (k == 12) begin
        chk("w16/busy_end", 32'(busy16), 32'h0);
      end
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bgn      = 1'b0;
    sgn      = 1'b1;
    ibus     = 8'h00;
    bgn16    = 1'b0;
    ibus16   = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst/obus", 32'(obus), 32'h0);
    chk("rst/stop", 32'(stop), 32'h0);
    chk("rst/busy", 32'(busy), 32'h0);
    chk("rst/obus16", 32'(obus16), 32'h0);
    rst = 1'b0;
    idle(1, "post_rst");

    // Basic operation and operand pairs (signed)
    op8(8'h02, 8'h03, 8'h06, 8'h00, 16'h0000, 0, 1'b1, "2x3");
    idle(2, "2x3");
    op8(8'hFB, 8'h07, 8'hDD, 8'hFF, 16'h0000, 0, 1'b1, "m5x7");
    idle(1, "m5x7");
    op8(8'h80, 8'h80, 8'h00, 8'h40, 16'h0000, 0, 1'b1, "80x80");
    idle(1, "80x80");
    op8(8'h7F, 8'h80, 8'h80, 8'hC0, 16'h0000, 0, 1'b1, "7Fx80");
    idle(1, "7Fx80");
    op8(8'h00, 8'h5A, 8'h00, 8'h00, 16'h0000, 0, 1'b1, "0x5A");
    idle(1, "0x5A");
    op8(8'h7F, 8'h7F, 8'h01, 8'h3F, 16'h0000, 0, 1'b1, "7Fx7F");
    idle(1, "7Fx7F");
    op8(8'hFF, 8'hFF, 8'h01, 8'h00, 16'h0000, 0, 1'b1, "m1xm1");
    idle(1, "m1xm1");

    // Reset in the middle of CALC: the operation is dropped with no stop pulse
    bgn = 1'b1; ibus = 8'h02; @(negedge clk);
    bgn = 1'b0; ibus = 8'h03; @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst/busy", 32'(busy), 32'h0);
    chk("midrst/obus", 32'(obus), 32'h0);
    chk("midrst/stop", 32'(stop), 32'h0);
    rst = 1'b0;
    stops = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (stop) stops++;
    end
    chk("midrst/no_stop", 32'(stops), 32'h0);
    op8(8'h02, 8'h03, 8'h06, 8'h00, 16'h0000, 0, 1'b1, "after_rst");
    idle(1, "after_rst");

    // bgn pulses in LOAD_Y (edge 1), CALC (edge 3) and OUT_HI (edge 7) are ignored
    op8(8'hFB, 8'h07, 8'hDD, 8'hFF, 16'h008A, 0, 1'b1, "bgn_pulse");
    idle(2, "bgn_pulse");

    // bgn held high: back-to-back operations 8 cycles apart
    op8(8'hFB, 8'h07, 8'hDD, 8'hFF, 16'h00FE, 0, 1'b1, "b2b_1");
    op8(8'h80, 8'h80, 8'h00, 8'h40, 16'h00FE, 0, 1'b1, "b2b_2");
    op8(8'h7F, 8'h80, 8'h80, 8'hC0, 16'h0000, 0, 1'b1, "b2b_3");
    idle(2, "b2b");

`ifdef BOOTH_UNSIGNED_EN
    op8(8'hFF, 8'hFF, 8'h01, 8'hFE, 16'h0000, 1, 1'b0, "uns_FFxFF");
    idle(1, "uns_FFxFF");
    op8(8'h80, 8'h80, 8'h00, 8'h40, 16'h0000, 1, 1'b0, "uns_80x80");
    idle(1, "uns_80x80");
    op8(8'hFF, 8'hFF, 8'h01, 8'h00, 16'h0000, 0, 1'b1, "sgn_FFxFF");
    idle(1, "sgn_FFxFF");
`endif

    // W=16 instance: stop rises 11 edges after bgn
    op16(16'h8000, 16'h7FFF, 16'h8000, 16'hC000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
